// File: rtl/spart_key_rx.sv
`timescale 1ns/1ps
// spart_key_rx
//   Receives 8N1 serial key commands and keeps a bitmap of held keys for the CPU.
//   Command byte: b[7]=1 press / 0 release, b[3:0]=key index, b[6:4] reserved (must be 0).
//   Byte 0x0F clears the whole bitmap.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx         in   asynchronous serial line, idle high
//   SPART_we   out  one-cycle pulse whenever SPART_keys is written by an accepted command
//   SPART_keys out  registered held-key bitmap, bit i = key i held
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//   busy       out  high while the receiver is not idle
module spart_key_rx #(
   parameter int unsigned BAUD_DIV = 868,
   parameter int unsigned NUM_KEYS = 13
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rx,
   output logic                SPART_we,
   output logic [NUM_KEYS-1:0] SPART_keys,
   output logic                frame_err,
   output logic                busy
);

   localparam logic [11:0] HALF_LOAD = 12'(BAUD_DIV / 2 - 1);
   localparam logic [11:0] FULL_LOAD = 12'(BAUD_DIV - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

   state_t              state_q, state_d;
   logic [11:0]         cnt_q, cnt_d;
   logic [2:0]          bit_q, bit_d;
   logic [7:0]          shift_q, shift_d;
   logic                rx_s1_q, rx_s2_q, rx_prev_q;
   logic [NUM_KEYS-1:0] keys_q, keys_d;
   logic                we_q, we_d;
   logic                ferr_q, ferr_d;

   logic                rx_fall;
   logic                cnt_zero;
   logic                stop_done;

   // rx_prev_q tracks the synchronized line in every state, so a line held low
   // through a bad stop bit never produces a second falling edge.
   assign rx_fall   = rx_prev_q & ~rx_s2_q;
   assign cnt_zero  = (cnt_q == '0);
   assign stop_done = (state_q == ST_STOP) && cnt_zero;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         keys_q    <= '0;
         we_q      <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_s1_q   <= rx;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         keys_q    <= keys_d;
         we_q      <= we_d;
         ferr_q    <= ferr_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         ST_IDLE: begin
            if (rx_fall) begin
               state_d = ST_START;
               cnt_d   = HALF_LOAD;
            end
         end
         ST_START: begin
            if (cnt_zero) begin
               if (!rx_s2_q) begin
                  state_d = ST_DATA;
                  cnt_d   = FULL_LOAD;
                  bit_d   = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 12'd1;
            end
         end
         ST_DATA: begin
            if (cnt_zero) begin
               shift_d = {rx_s2_q, shift_q[7:1]};
               cnt_d   = FULL_LOAD;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
               end
            end else begin
               cnt_d = cnt_q - 12'd1;
            end
         end
         ST_STOP: begin
            if (cnt_zero) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 12'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      keys_d = keys_q;
      we_d   = 1'b0;
      ferr_d = 1'b0;
      busy   = (state_q != ST_IDLE);
      if (stop_done) begin
         if (!rx_s2_q) begin
            ferr_d = 1'b1;
         end else if (shift_q[6:4] == 3'b000) begin
            if (shift_q == 8'h0F) begin
               keys_d = '0;
               we_d   = 1'b1;
            end else begin
               // Out-of-range indices match no bit and are dropped silently.
               for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                  if (i == 32'(shift_q[3:0])) begin
                     keys_d[i] = shift_q[7];
                     we_d      = 1'b1;
                  end
               end
            end
         end
      end
   end

   assign SPART_we   = we_q;
   assign SPART_keys = keys_q;
   assign frame_err  = ferr_q;

endmodule

// File: tb/tb_spart_key_rx.sv
`timescale 1ns/1ps
module tb_spart_key_rx;

   localparam int unsigned BD = 16;
   localparam int unsigned NK = 13;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rx = 1'b1;
   logic          SPART_we;
   logic [NK-1:0] SPART_keys;
   logic          frame_err;
   logic          busy;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   int unsigned we_cnt = 0;
   int unsigned fe_cnt = 0;
   logic        prev_we = 1'b0;
   logic        consec_we = 1'b0;
   logic [NK-1:0] keys_log [$];

   int unsigned we0, fe0, log0;

   spart_key_rx #(.BAUD_DIV(BD), .NUM_KEYS(NK)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .SPART_we   (SPART_we),
      .SPART_keys (SPART_keys),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (SPART_we) begin
         we_cnt++;
         keys_log.push_back(SPART_keys);
      end
      if (frame_err) fe_cnt++;
      if (SPART_we && prev_we) consec_we = 1'b1;
      prev_we = SPART_we;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic v);
      rx = v;
      repeat (BD) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
      rx = 1'b1;
   endtask

   task automatic mark();
      we0  = we_cnt;
      fe0  = fe_cnt;
      log0 = keys_log.size();
   endtask

   function automatic logic [31:0] log_at(input int unsigned idx);
      if (idx < keys_log.size()) return 32'(keys_log[idx]);
      return 32'hDEAD_BEEF;
   endfunction

   initial begin
      // reset state
      idle(3);
      check_eq("rst_keys", 32'(SPART_keys), 32'h0);
      check_eq("rst_we",   32'(SPART_we),   32'h0);
      check_eq("rst_ferr", 32'(frame_err),  32'h0);
      check_eq("rst_busy", 32'(busy),       32'h0);
      rst_n = 1'b1;
      idle(10);

      // press / release key 3
      mark();
      send_byte(8'h83, 1'b1);
      idle(20);
      check_eq("p3_we",   we_cnt - we0, 1);
      check_eq("p3_keys", 32'(SPART_keys), 32'h0008);
      check_eq("p3_busy", 32'(busy), 32'h0);
      mark();
      send_byte(8'h03, 1'b1);
      idle(20);
      check_eq("r3_we",   we_cnt - we0, 1);
      check_eq("r3_keys", 32'(SPART_keys), 32'h0000);

      // back-to-back bytes, single stop bit each
      mark();
      send_byte(8'h8C, 1'b1);
      send_byte(8'h80, 1'b1);
      send_byte(8'h0F, 1'b1);
      idle(20);
      check_eq("b2b_we",   we_cnt - we0, 3);
      check_eq("b2b_k0",   log_at(log0),     32'h1000);
      check_eq("b2b_k1",   log_at(log0 + 1), 32'h1001);
      check_eq("b2b_k2",   log_at(log0 + 2), 32'h0000);
      check_eq("b2b_keys", 32'(SPART_keys), 32'h0000);

      // set key 1, then ignored commands and a framing error
      mark();
      send_byte(8'h81, 1'b1);
      idle(20);
      check_eq("p1_keys", 32'(SPART_keys), 32'h0002);
      mark();
      send_byte(8'h8D, 1'b1);
      send_byte(8'hA1, 1'b1);
      send_byte(8'h83, 1'b0);
      idle(20);
      check_eq("ign_we",   we_cnt - we0, 0);
      check_eq("ign_keys", 32'(SPART_keys), 32'h0002);
      check_eq("ign_ferr", fe_cnt - fe0, 1);

      // short glitch while idle
      mark();
      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      idle(2);
      check_eq("gl_busy_mid", 32'(busy), 32'h1);
      idle(20);
      check_eq("gl_busy_end", 32'(busy), 32'h0);
      check_eq("gl_we",   we_cnt - we0, 0);
      check_eq("gl_ferr", fe_cnt - fe0, 0);

      // line stuck low: one frame error, then silence
      mark();
      rx = 1'b0;
      idle(BD * 10 + 200);
      check_eq("low_ferr", fe_cnt - fe0, 1);
      check_eq("low_we",   we_cnt - we0, 0);
      check_eq("low_busy", 32'(busy), 32'h0);
      rx = 1'b1;
      idle(20);
      check_eq("low_keys", 32'(SPART_keys), 32'h0002);

      // repeated press still pulses, then reset mid-byte
      mark();
      send_byte(8'h81, 1'b1);
      idle(20);
      check_eq("rep_we",   we_cnt - we0, 1);
      check_eq("rep_keys", 32'(SPART_keys), 32'h0002);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      check_eq("mid_busy", 32'(busy), 32'h1);
      rst_n = 1'b0;
      rx    = 1'b1;
      #1;
      check_eq("ar_keys", 32'(SPART_keys), 32'h0);
      idle(2);
      check_eq("ar_busy", 32'(busy), 32'h0);
      mark();
      rst_n = 1'b1;
      idle(BD * 12);
      check_eq("ar_we",   we_cnt - we0, 0);
      check_eq("ar_ferr", fe_cnt - fe0, 0);
      mark();
      send_byte(8'h82, 1'b1);
      idle(20);
      check_eq("p2_we",   we_cnt - we0, 1);
      check_eq("p2_keys", 32'(SPART_keys), 32'h0004);

      check_eq("we_consec", 32'(consec_we), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spart_key_rx.md
SPART_KEY_RX -- requirements
Module: spart_key_rx

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 868, meaning clk cycles per serial bit (100 MHz / 115200); legal range 8..4095.
REQ-002 The block SHALL have parameter NUM_KEYS, default 13, meaning the width of the key bitmap.
REQ-003 The block SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port rx  input  1  asynchronous serial line, 8N1, idle high.
REQ-006 The block SHALL have port SPART_we  output  1  one-cycle pulse marking a SPART_keys update to the CPU.
REQ-007 The block SHALL have port SPART_keys  output  NUM_KEYS  registered held-key bitmap (bit i = key i held).
REQ-008 The block SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-009 The block SHALL have port busy  output  1  high whenever the receive FSM is not in IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value.
REQ-011 The receive FSM SHALL have states IDLE, START, DATA, STOP.
REQ-012 IDLE->START SHALL occur on a synchronized rx high-to-low transition; the bit counter loads BAUD_DIV/2 - 1 (integer division).
REQ-013 In START at counter expiry: rx low -> DATA with the counter loaded to BAUD_DIV-1; rx high -> glitch, return to IDLE, no output.
REQ-014 DATA SHALL sample rx every BAUD_DIV cycles, 8 samples, LSB first, into an 8-bit shift register, then go to STOP.
REQ-015 STOP SHALL sample rx after BAUD_DIV cycles: high -> byte valid; low -> frame_err pulses one cycle and the byte is discarded; both cases return to IDLE.
REQ-016 Valid byte decode SHALL be: b[7]=1 press, b[7]=0 release, b[3:0]=key index k, b[6:4] reserved.
REQ-017 b[6:4]!=0 SHALL be ignored: no SPART_we, SPART_keys unchanged.
REQ-018 Press with k<NUM_KEYS SHALL set SPART_keys[k]; release with k<NUM_KEYS SHALL clear SPART_keys[k].
REQ-019 Byte 0x0F (release, k=15) SHALL clear all SPART_keys bits; any other k>=NUM_KEYS SHALL be ignored.
REQ-020 Each accepted command SHALL update SPART_keys and pulse SPART_we on the same cycle, the cycle after the stop-bit sample, even when the bitmap value does not change.
REQ-021 SPART_we SHALL never be high on two consecutive cycles.
REQ-022 A new start edge SHALL be detectable on the first IDLE cycle after STOP, so back-to-back bytes with one stop bit are all received.
REQ-023 rx held low continuously SHALL produce one frame_err and then no further activity until rx returns high and falls again.

Reset
REQ-024 While rst_n is low: FSM=IDLE, counters=0, shift register=0, synchronizer flops=1, SPART_keys=0, SPART_we=0, frame_err=0, busy=0.
REQ-025 rst_n asserted mid-byte SHALL abort the byte without output; after release the block waits for a fresh falling edge.

Verification (BAUD_DIV=16 in simulation)
REQ-026 Send 0x83 -> one SPART_we pulse, SPART_keys=13'h0008; then send 0x03 -> one pulse, SPART_keys=13'h0000.
REQ-027 Send 0x8C, 0x80, 0x0F back-to-back with one stop bit each -> three pulses, SPART_keys 13'h1000, then 13'h1001, then 13'h0000.
REQ-028 Send 0x8D, 0xA1, then 0x83 with the stop bit driven low -> no SPART_we, SPART_keys unchanged, exactly one frame_err pulse.
REQ-029 rx low pulse of 4 cycles while IDLE -> return to IDLE after START, no SPART_we, no frame_err.
REQ-030 Assert rst_n low during DATA of 0x85 after 0x81 was accepted -> SPART_keys=0 immediately; after release, send 0x82 -> SPART_keys=13'h0004.
